event_capture_core: RTL
=======================

EVENT_CAPTURE_CORE -- requirements
Module: event_capture_core

Interface
REQ-001 Parameter N_CH, default 8, number of sampled channels (1..32).
REQ-002 Parameter TS_W, default 24, width of the delta-timestamp field (8..32).
REQ-003 Parameter DEPTH, default 16, event FIFO entries (power of two, >=2).
REQ-004 Port clk  input  1  single clock; all logic rising-edge.
REQ-005 Port rst  input  1  reset, synchronous, active-low.
REQ-006 Port pin_values  input  N_CH  asynchronous channel inputs.
REQ-007 Port arm  input  1  level; 1 = capture enabled, 0 = return to idle.
REQ-008 Port trig_mask  input  N_CH  channels participating in the trigger.
REQ-009 Port trig_value  input  N_CH  required levels of the masked channels.
REQ-010 Port byte_taken  input  1  one-cycle pulse from the SPI reader: current tx_byte consumed.
REQ-011 Port tx_byte  output  8  byte presented to the SPI reader.
REQ-012 Port overflow  output  1  sticky; an event was dropped since the last reported record.
REQ-013 Port fifo_level  output  log2(DEPTH)+1  occupied FIFO entries.
REQ-014 Port capturing  output  1  high in state CAPTURE.

Function
REQ-015 pin_values SHALL pass a 2-flop synchroniser; all later logic uses the synchronised value S.
REQ-016 Controller states SHALL be IDLE, ARMED and CAPTURE; IDLE->ARMED when arm=1; ARMED->CAPTURE when (S & trig_mask) == (trig_value & trig_mask); any state->IDLE when arm=0.
REQ-017 trig_mask = 0 SHALL trigger on the first ARMED cycle.
REQ-018 The ARMED->CAPTURE transition SHALL push one trigger event {ts=0, pins=S}.
REQ-019 In CAPTURE, a delta counter SHALL count cycles since the last pushed event and reset to 0 on every push.
REQ-020 In CAPTURE, S != previous S SHALL push event {ts=delta, pins=S} in the cycle after S changes (3 clk from input edge to FIFO write).
REQ-021 The delta counter reaching all-ones SHALL force a keepalive push {ts=all-ones, pins=S}, even if S is unchanged.
REQ-022 A push with the FIFO full SHALL be dropped and set overflow; a simultaneous push and pop at full SHALL both be performed, with no drop.
REQ-023 Record = status byte + PB payload bytes, PB = ceil((TS_W+N_CH)/8); payload = {zero pad, ts, pins}, right-justified, sent MSB byte first.
REQ-024 Status byte SHALL be {1, ovf, 6'b0}, where ovf = overflow at pop time; popping SHALL clear overflow, unless a drop occurs in the same cycle.
REQ-025 Serialiser: on byte_taken mid-record, tx_byte SHALL advance to the next payload byte on the next cycle.
REQ-026 Serialiser: on byte_taken after the last byte (or while idle), it SHALL pop and present the status byte if the FIFO is non-empty, else present 0x00.
REQ-027 tx_byte SHALL stay stable between byte_taken pulses; byte_taken while the FIFO is empty and no record is active SHALL keep 0x00.
REQ-028 Entering IDLE SHALL NOT flush the FIFO; stored records remain drainable.
REQ-029 fifo_level SHALL reflect the push/pop of a cycle one cycle later.

Reset
REQ-030 When rst=0 at a clock edge: state IDLE, FIFO empty, delta 0, synchroniser 0, serialiser idle.
REQ-031 Reset output values: tx_byte 0x00, overflow 0, fifo_level 0, capturing 0.
REQ-032 Reset mid-record SHALL abandon the record; the first byte after reset is 0x00.

Structure
REQ-033 A shared package SHALL hold the state enum, the status-byte bit positions, the idle byte 0x00, and the PB/record-width calculations.
REQ-034 The FIFO SHALL be a separate sub-module, event_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level).
REQ-035 The synchroniser, controller and serialiser SHALL remain in event_capture_core.

Verification (defaults N_CH=8, TS_W=24, DEPTH=16; record = 5 bytes)
REQ-036 Reset, then 3 byte_taken pulses -> tx_byte 0x00 throughout; fifo_level 0.
REQ-037 arm=1, mask=0x01, value=0x01, pins 0x00->0x01 -> capturing rises; drained bytes 80 00 00 00 01.
REQ-038 After trigger, pins 0x01->0x03 with 100 idle cycles between -> second record 80 00 00 64 03.
REQ-039 TS_W=8, no pin activity for 300 cycles after trigger -> keepalive records with ts=FF, pins unchanged.
REQ-040 18 pin toggles with no draining -> fifo_level 16; overflow 1; first drained status byte C0; the next status byte is 80.
REQ-041 rst=0 during byte 3 of a record -> tx_byte 0x00; FIFO empty; state IDLE; a new arm restarts capture cleanly.

Source files
------------

// File: rtl/event_capture_pkg.sv
// Shared constants for the event capture core: controller state encoding,
// status-byte layout, idle byte and record sizing helpers.
package event_capture_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // Status byte layout: {valid, ovf, 6'b0}
    localparam int STATUS_VALID_BIT = 7;
    localparam int STATUS_OVF_BIT   = 6;

    // Byte presented whenever no record is being sent
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    // Payload bytes needed for one {ts, pins} event, rounded up to whole bytes
    function automatic int payload_bytes(input int ts_w, input int n_ch);
        return (ts_w + n_ch + 7) / 8;
    endfunction

    // Width of the right-justified, zero-padded payload in bits
    function automatic int payload_bits(input int ts_w, input int n_ch);
        return payload_bytes(ts_w, n_ch) * 8;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Event FIFO: show-ahead read data, registered occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module event_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign count_d  = count_q + CW'(do_push) - CW'(do_pop);
    assign pop_data = mem[rd_ptr_q];
    assign level    = count_q;

    // Write accepted events into storage.
    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Advance pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: non-blocking assignments so every flop sees the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/event_capture_core.sv
// Event capture core: synchronises channel pins, waits for a masked trigger,
// then logs every pin change (plus keepalives) as {delta ts, pins} events and
// serialises them byte by byte to an SPI reader.
module event_capture_core
    import event_capture_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int TS_W  = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          pin_values,
    input  logic                     arm,
    input  logic [N_CH-1:0]          trig_mask,
    input  logic [N_CH-1:0]          trig_value,
    input  logic                     byte_taken,
    output logic [7:0]               tx_byte,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     capturing
);
    localparam int EV_W  = TS_W + N_CH;
    localparam int PB    = payload_bytes(TS_W, N_CH);
    localparam int REC_W = payload_bits(TS_W, N_CH);
    localparam int BL_W  = 4;

    logic [N_CH-1:0]  sync_q, s_q, s_prev_q;
    logic [1:0]       state_q, state_d;
    logic [TS_W-1:0]  delta_q, delta_d;
    logic             trig_hit;
    logic             push;
    logic [EV_W-1:0]  push_data;
    logic             pop;
    logic [EV_W-1:0]  pop_data;
    logic             fifo_full, fifo_empty;
    logic             drop;
    logic             overflow_q, overflow_d;
    logic [7:0]       tx_q, tx_d, status;
    logic [REC_W-1:0] shift_q, shift_d;
    logic [BL_W-1:0]  left_q, left_d;

    event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign trig_hit  = ((s_q & trig_mask) == (trig_value & trig_mask));
    assign drop      = push && fifo_full && !pop;
    assign capturing = (state_q == ST_CAPTURE);
    assign tx_byte   = tx_q;
    assign overflow  = overflow_q;

    // Two-flop synchroniser plus a one-cycle history of the synchronised pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q   <= '0;
            s_q      <= '0;
            s_prev_q <= '0;
        end else begin
            sync_q   <= pin_values;
            s_q      <= sync_q;
            s_prev_q <= s_q;
        end
    end

    // Controller: arm/trigger sequencing and event generation with the delta timestamp.
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        delta_d   = '0;
        push      = 1'b0;
        push_data = {TS_W'(0), s_q};
        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (trig_hit) begin
                        state_d = ST_CAPTURE;
                        push    = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // A keepalive carries ts = all-ones, which is exactly delta_q at that point.
                    if ((s_q != s_prev_q) || (delta_q == '1)) begin
                        push      = 1'b1;
                        push_data = {delta_q, s_q};
                    end else begin
                        delta_d = delta_q + TS_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Controller state and delta counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            delta_q <= '0;
        end else begin
            state_q <= state_d;
            delta_q <= delta_d;
        end
    end

    // Serialiser: status byte on pop, then payload bytes MSB first, idle byte when empty.
    always_comb begin
        tx_d    = tx_q;
        shift_d = shift_q;
        left_d  = left_q;
        pop     = 1'b0;
        status  = IDLE_BYTE;
        status[STATUS_VALID_BIT] = 1'b1;
        status[STATUS_OVF_BIT]   = overflow_q;
        if (byte_taken) begin
            if (left_q != '0) begin
                tx_d    = shift_q[REC_W-1 -: 8];
                shift_d = shift_q << 8;
                left_d  = left_q - BL_W'(1);
            end else if (!fifo_empty) begin
                pop     = 1'b1;
                tx_d    = status;
                shift_d = REC_W'(pop_data);
                left_d  = BL_W'(PB);
            end else begin
                tx_d = IDLE_BYTE;
            end
        end
    end

    // Sticky overflow: set by a drop, cleared when a record reports it.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (pop) begin
            overflow_d = 1'b0;
        end
    end

    // Serialiser and overflow registers; reset abandons any record in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_q       <= IDLE_BYTE;
            shift_q    <= '0;
            left_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
